ordenador_secuencial: RTL and testbench

Sequential sort controller that schedules a single shared 3-bit magnitude comparator to order a burst of N values. It accepts N values over a valid/ready input stream and bubble-sorts them in a local buffer, one comparison per cycle. It then streams the values out in ascending order over a valid/ready output stream. It sits between a value producer and any consumer that needs ordered data, and owns the only comparator instance in its path.

---
 rtl/ord_pkg.sv | 15 +
 rtl/cmp3_unit.sv | 21 ++
 rtl/ordenador_secuencial.sv | 144 ++++++++++++++
 tb/tb_ordenador_secuencial.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ord_pkg.sv
// Shared encodings for the sequential sort controller: FSM states and
// the 3-bit comparator result codes.
package ord_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SORT  = 2'd1,
    ST_DRAIN = 2'd2
  } ord_state_t;

  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b000;
  localparam logic [2:0] CMP_LT = 3'b001;

endpackage

// File: rtl/cmp3_unit.sv
// Combinational magnitude comparator returning a one-of-three code.
// One instance is time-shared by the sort controller.
module cmp3_unit
  import ord_pkg::*;
#(
  parameter int W = 3
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [2:0]   code
);

  // Greater-than takes priority; equality falls through to CMP_EQ so the
  // sorter never swaps equal elements.
  always_comb begin
    code = CMP_LT;
    if (a > b)       code = CMP_GT;
    else if (a == b) code = CMP_EQ;
  end

endmodule

// File: rtl/ordenador_secuencial.sv
// Sequential bubble-sort controller: loads N elements over a valid/ready
// stream, sorts them with a single shared comparator (one compare per
// cycle, early exit on a swap-free pass), then drains them ascending.
// Optional swap counter port enabled by defining ORD_SWAP_COUNT_EN.
module ordenador_secuencial
  import ord_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy
`ifdef ORD_SWAP_COUNT_EN
  ,
  output logic [7:0]   swap_count
`endif
);

  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = AW + 1;

  ord_state_t     state;
  logic [W-1:0]   mem [N];
  logic [IW-1:0]  load_idx;
  logic [IW-1:0]  pass;
  logic [IW-1:0]  idx;
  logic [IW-1:0]  k;
  logic           swapped;

  logic [W-1:0]   cmp_a;
  logic [W-1:0]   cmp_b;
  logic [2:0]     code;
  logic           gt;
  logic           swapped_now;
  logic           last_cmp;

  assign cmp_a       = mem[AW'(idx)];
  assign cmp_b       = mem[AW'(idx + 1'b1)];
  assign gt          = (code == CMP_GT);
  assign swapped_now = swapped | gt;
  assign last_cmp    = (idx == IW'(N - 2) - pass);

  cmp3_unit #(.W(W)) u_cmp (
    .a    (cmp_a),
    .b    (cmp_b),
    .code (code)
  );

`ifdef ORD_SWAP_COUNT_EN
  // Swaps in the current/last sort; cleared by the first accept of a burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      swap_count <= '0;
    end else if (state == ST_LOAD && in_valid && in_ready && load_idx == '0) begin
      swap_count <= '0;
    end else if (state == ST_SORT && gt && swap_count != 8'hFF) begin
      swap_count <= swap_count + 8'd1;
    end
  end
`endif

  // Main FSM with registered handshake outputs; in_ready is registered so it
  // is already low in the cycle of the last drain handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_LOAD;
      load_idx  <= '0;
      pass      <= '0;
      idx       <= '0;
      k         <= '0;
      swapped   <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      for (int j = 0; j < N; j++) mem[j] <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            mem[AW'(load_idx)] <= in_data;
            if (load_idx == IW'(N - 1)) begin
              state    <= ST_SORT;
              load_idx <= '0;
              pass     <= '0;
              idx      <= '0;
              swapped  <= 1'b0;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end else begin
              load_idx <= load_idx + 1'b1;
            end
          end
        end
        ST_SORT: begin
          if (gt) begin
            mem[AW'(idx)]        <= cmp_b;
            mem[AW'(idx + 1'b1)] <= cmp_a;
          end
          if (last_cmp) begin
            if (!swapped_now || pass == IW'(N - 2)) begin
              state     <= ST_DRAIN;
              k         <= '0;
              out_valid <= 1'b1;
              // Element 0 may be rewritten by this very compare.
              out_data  <= (idx == '0 && gt) ? cmp_b : mem[0];
            end else begin
              pass    <= pass + 1'b1;
              idx     <= '0;
              swapped <= 1'b0;
            end
          end else begin
            idx     <= idx + 1'b1;
            swapped <= swapped_now;
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            if (k == IW'(N - 1)) begin
              state     <= ST_LOAD;
              k         <= '0;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
            end else begin
              k        <= k + 1'b1;
              out_data <= mem[AW'(k + 1'b1)];
            end
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_ordenador_secuencial.sv
// Self-checking bench for ordenador_secuencial (N=4, W=3): directed test-plan
// bursts plus randomized bursts against an array-level sorting model.
module tb_ordenador_secuencial;

  localparam int N = 4;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         busy;
`ifdef ORD_SWAP_COUNT_EN
  logic [7:0]   swap_count;
`endif

  int total = 0;
  int bad   = 0;

  ordenador_secuencial #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef ORD_SWAP_COUNT_EN
    ,
    .swap_count(swap_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: sorted order, inversion count (= bubble swaps), and compare
  // cycles from the number of passes bubble sort needs (max left shift + 1).
  task automatic model(input int v[N], output int s[N], output int inv, output int cyc);
    int maxl, l, passes;
    s = v;
    for (int i = 1; i < N; i++)
      for (int j = i; j > 0 && s[j-1] > s[j]; j--) begin
        int t = s[j]; s[j] = s[j-1]; s[j-1] = t;
      end
    inv = 0; maxl = 0;
    for (int i = 0; i < N; i++) begin
      l = 0;
      for (int j = 0; j < i; j++) if (v[j] > v[i]) l++;
      inv += l;
      if (l > maxl) maxl = l;
    end
    passes = (maxl + 1 > N - 1) ? N - 1 : maxl + 1;
    cyc = 0;
    for (int p = 0; p < passes; p++) cyc += N - 1 - p;
  endtask

  // mode: 0 = out_ready high, 1 = toggling 1,0,..., 2 = random
  task automatic run_burst(input int v[N], input int mode, input bit hold_in, input string nm);
    int s[N], inv, cyc, n, hs, guard, illegal;
    bit rb, vb;
    logic [W-1:0] db;
    model(v, s, inv, cyc);
    rb = in_ready;
    n = 0; guard = 0;
    while (n < N && guard < 100) begin
      in_valid = 1'b1; in_data = W'(v[n]);
      vb = in_ready;
      tick(); guard++;
      if (vb) n++;
    end
    total++;
    if (n != N) begin bad++; $display("FAIL %s load timeout accepted=%0d want=%0d", nm, n, N); end
    if (rb) begin
      total++;
      if (guard != N) begin bad++; $display("FAIL %s load_cycles got=%0d want=%0d", nm, guard, N); end
    end
    in_valid = hold_in; illegal = 0;
    n = 0;
    while (!out_valid && n < 200) begin
      if (hold_in) in_data = W'($urandom_range(0, 7));
      if (in_ready && in_valid) illegal++;
      tick(); n++;
    end
    total++;
    if (n != cyc) begin bad++; $display("FAIL %s sort_cycles got=%0d want=%0d", nm, n, cyc); end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL %s busy_in_drain got=%b want=1", nm, busy); end
`ifdef ORD_SWAP_COUNT_EN
    total++;
    if (swap_count !== 8'(inv)) begin bad++; $display("FAIL %s swap_count got=%0d want=%0d", nm, swap_count, inv); end
`endif
    hs = 0; n = 0;
    while (hs < N && n < 200) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (n % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (hold_in) in_data = W'($urandom_range(0, 7));
      if (in_ready && in_valid) illegal++;
      vb = out_valid; db = out_data;
      tick(); n++;
      total++;
      if (!vb) begin
        bad++; $display("FAIL %s drain_bubble out_valid=0 want=1 at handshake %0d", nm, hs);
      end else if (out_ready) begin
        if (db !== W'(s[hs])) begin bad++; $display("FAIL %s out_data[%0d] got=%0d want=%0d", nm, hs, db, s[hs]); end
        hs++;
      end else if (out_valid !== 1'b1 || out_data !== db) begin
        bad++; $display("FAIL %s hold got=%b/%0d want=1/%0d", nm, out_valid, out_data, db);
      end
    end
    out_ready = 1'b0;
    total++;
    if (hs != N) begin bad++; $display("FAIL %s drain timeout handshakes=%0d want=%0d", nm, hs, N); end
    if (mode == 0) begin
      total++;
      if (n != N) begin bad++; $display("FAIL %s drain_cycles got=%0d want=%0d", nm, n, N); end
    end
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL %s post_drain valid/busy/ready got=%b%b%b want=001", nm, out_valid, busy, in_ready);
    end
    total++;
    if (illegal != 0) begin bad++; $display("FAIL %s accepts_while_busy got=%0d want=0", nm, illegal); end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset ready/valid/data/busy got=%b%b%0d%b want=0000", in_ready, out_valid, out_data, busy);
    end
`ifdef ORD_SWAP_COUNT_EN
    total++;
    if (swap_count !== 8'd0) begin bad++; $display("FAIL reset swap_count got=%0d want=0", swap_count); end
`endif
    rst = 1'b0;
    tick();
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_directed();
    run_burst('{5, 1, 4, 2}, 0, 1'b0, "worst_5142");
    run_burst('{0, 3, 3, 7}, 0, 1'b0, "sorted_0337");
    run_burst('{7, 7, 7, 7}, 1, 1'b0, "equal_toggle");
    run_burst('{3, 6, 0, 5}, 0, 1'b1, "hold_in_valid");
  endtask

  task automatic test_reset_mid_sort();
    int v[N] = '{5, 1, 4, 2};
    int n = 0;
    int guard = 0;
    bit vb;
    while (n < N && guard < 50) begin
      in_valid = 1'b1; in_data = W'(v[n]); vb = in_ready;
      tick(); guard++;
      if (vb) n++;
    end
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0) begin
      bad++; $display("FAIL midsort_reset ready/valid/data/busy got=%b%b%0d%b want=0000", in_ready, out_valid, out_data, busy);
    end
    rst = 1'b0;
    tick();
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL midsort_release in_ready got=%b want=1", in_ready); end
    run_burst('{6, 2, 5, 1}, 0, 1'b0, "after_reset_6251");
  endtask

  task automatic test_back_to_back();
    run_burst('{4, 3, 2, 1}, 0, 1'b0, "b2b_4321");
    run_burst('{1, 2, 3, 4}, 0, 1'b0, "b2b_1234");
  endtask

  task automatic test_random();
    int v[N];
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < N; i++) v[i] = int'($urandom_range(0, 7));
      run_burst(v, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_sort();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
